trace_plotter: RTL and testbench

//  Write-side client of the oscilloscope framebuffer. On each start it clears the frame,

---
 rtl/trace_plotter.sv | 151 +++++++++++++++
 tb/tb_trace_plotter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_plotter.sv
// trace_plotter: write-side client of the scope framebuffer. Clears the frame,
// then takes one ADC sample per column and draws it, joining neighbouring
// samples with a vertical pixel run so the trace stays continuous.
module trace_plotter #(
  parameter int unsigned            COLOR_DEPTH   = 1,
  parameter int unsigned            SCREEN_WIDTH  = 640,
  parameter int unsigned            SCREEN_HEIGHT = 480,
  parameter int unsigned            SAMPLE_WIDTH  = 8,
  parameter logic [COLOR_DEPTH-1:0] TRACE_COLOR   = COLOR_DEPTH'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    clear,
  input  logic                    clear_done,
  output logic [9:0]              write_h,
  output logic [9:0]              write_v,
  output logic [COLOR_DEPTH-1:0]  write_data,
  output logic                    wren
);

  localparam int unsigned HW       = $clog2(SCREEN_HEIGHT + 1);
  localparam int unsigned PW       = SAMPLE_WIDTH + HW;
  localparam logic [9:0]  LAST_COL = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(SCREEN_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_CLEAR,
    S_WAIT_SAMPLE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t     r_state;
  logic       r_busy;
  logic       r_frame_done;
  logic       r_sample_ready;
  logic       r_clear;
  logic       r_wren;
  logic [9:0] r_write_h;   // doubles as the column counter
  logic [9:0] r_write_v;   // current row of the vertical run
  logic [9:0] r_y_hi;      // last row of the current run
  logic [9:0] r_prev_v;    // row of the previous column's sample

  logic [PW-1:0] w_prod;
  logic [HW-1:0] w_scaled;
  logic [9:0]    w_v;
  logic [9:0]    w_lo;
  logic [9:0]    w_hi;

  // Map the incoming sample to a row (0 = bottom) and span it against the previous column.
  always_comb begin
    w_prod   = PW'(sample_data) * PW'(SCREEN_HEIGHT);
    w_scaled = HW'(w_prod >> SAMPLE_WIDTH);
    w_v      = LAST_ROW - 10'(w_scaled);
    w_lo     = w_v;
    w_hi     = w_v;
    if (r_write_h != '0) begin
      w_lo = (r_prev_v < w_v) ? r_prev_v : w_v;
      w_hi = (r_prev_v > w_v) ? r_prev_v : w_v;
    end
  end

  // Frame sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sample_ready <= 1'b0;
      r_clear        <= 1'b0;
      r_wren         <= 1'b0;
      r_write_h      <= '0;
      r_write_v      <= '0;
      r_y_hi         <= '0;
      r_prev_v       <= '0;
    end else begin
      r_clear      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CLEAR;
            r_clear   <= 1'b1;
            r_busy    <= 1'b1;
            r_write_h <= '0;
          end
        end
        // clear_done arriving in this cycle belongs to an older clear and is ignored
        S_CLEAR: begin
          r_state <= S_WAIT_CLEAR;
        end
        S_WAIT_CLEAR: begin
          if (clear_done) begin
            r_state        <= S_WAIT_SAMPLE;
            r_sample_ready <= 1'b1;
          end
        end
        S_WAIT_SAMPLE: begin
          if (sample_valid) begin
            r_state        <= S_DRAW;
            r_sample_ready <= 1'b0;
            r_wren         <= 1'b1;
            r_write_v      <= w_lo;
            r_y_hi         <= w_hi;
            r_prev_v       <= w_v;
          end
        end
        S_DRAW: begin
          if (r_write_v == r_y_hi) begin
            r_wren <= 1'b0;
            if (r_write_h == LAST_COL) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_state        <= S_WAIT_SAMPLE;
              r_sample_ready <= 1'b1;
              r_write_h      <= r_write_h + 10'd1;
            end
          end else begin
            r_write_v <= r_write_v + 10'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign sample_ready = r_sample_ready;
  assign clear        = r_clear;
  assign wren         = r_wren;
  assign write_h      = r_write_h;
  assign write_v      = r_write_v;
  assign write_data   = TRACE_COLOR;

endmodule

// File: tb/tb_trace_plotter.sv
// tb_trace_plotter: drives frames of ADC samples into trace_plotter, models the
// framebuffer clear handshake, records every pixel write and compares it with
// a column-by-column reference computed from the plotting rules.
module tb_trace_plotter;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int SW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       clear_done = 1'b0;
  logic [7:0] sample_data = '0;
  logic       busy, frame_done, sample_ready, clear, wren;
  logic [9:0] write_h, write_v;
  logic [0:0] write_data;

  int n_checks = 0;
  int n_fail   = 0;

  trace_plotter #(
    .COLOR_DEPTH  (1),
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .SAMPLE_WIDTH (SW),
    .TRACE_COLOR  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .frame_done  (frame_done),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .clear       (clear),
    .clear_done  (clear_done),
    .write_h     (write_h),
    .write_v     (write_v),
    .write_data  (write_data),
    .wren        (wren)
  );

  always #5 clk = ~clk;

  // sample source, framebuffer model and observation state
  int samp[$];
  int src_q[$];
  int got_h[$], got_v[$];
  int exp_h[$], exp_v[$];
  bit src_rand = 1'b0;
  bit early_mode = 1'b0;
  bit src_v;
  int clear_delay = 4;
  int cd_cnt = 0;
  bit pend = 1'b0;
  int n_clear = 0, n_done = 0, n_pre_act = 0, n_lat_err = 0, n_gap_err = 0;
  int n_busy_err = 0, n_overlap = 0, n_bad_data = 0, n_idle_act = 0;
  bit busy_at_done = 1'b0, in_frame = 1'b0, prev_wren = 1'b0, lat_pending = 1'b0;

  always @(negedge clk) begin
    // observe
    if (lat_pending && !wren) n_lat_err++;
    lat_pending = 1'b0;
    if (clear) begin n_clear++; in_frame = 1'b1; end
    if (pend && (wren || sample_ready)) n_pre_act++;
    if (wren) begin
      got_h.push_back(int'(write_h));
      got_v.push_back(int'(write_v));
      if (write_data !== 1'b1) n_bad_data++;
    end
    if (wren && sample_ready) n_overlap++;
    if (prev_wren && !wren && !sample_ready && !frame_done) n_gap_err++;
    prev_wren = wren;
    if (frame_done) begin
      n_done++;
      busy_at_done = busy;
      in_frame = 1'b0;
    end else if (in_frame && !busy) n_busy_err++;
    if (!in_frame && !frame_done && (sample_ready || wren)) n_idle_act++;
    // framebuffer clear handshake
    clear_done = 1'b0;
    if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) begin clear_done = 1'b1; pend = 1'b0; end
    end
    if (clear) begin
      cd_cnt = clear_delay;
      pend = 1'b1;
      if (early_mode) clear_done = 1'b1;
    end
    // sample source; a transfer happens at the next rising edge if valid && ready now
    if (src_q.size() > 0) begin
      src_v = src_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      sample_valid = src_v;
      sample_data = src_v ? 8'(src_q[0]) : 8'($urandom);
      if (src_v && sample_ready && !rst) begin
        void'(src_q.pop_front());
        lat_pending = 1'b1;
      end
    end else begin
      sample_valid = 1'b0;
      sample_data = 8'($urandom);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic mon_clear();
    got_h.delete(); got_v.delete();
    n_clear = 0; n_done = 0; n_pre_act = 0; n_lat_err = 0; n_gap_err = 0;
    n_busy_err = 0; n_overlap = 0; n_bad_data = 0; n_idle_act = 0;
    busy_at_done = 1'b0; in_frame = 1'b0; prev_wren = 1'b0; lat_pending = 1'b0;
  endtask

  task automatic run_frame(input bit poke, output bit to);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 30000 && n_done == 0; i++) begin
      start = poke && ($urandom_range(0, 39) == 0);
      tick(1);
    end
    start = 1'b0;
    to = (n_done == 0);
    tick(4);
  endtask

  // reference: row of a sample, then per column the run between previous and current row
  function automatic int row_of(int s);
    return (H - 1) - (s * H) / (1 << SW);
  endfunction

  task automatic build_expected();
    int prev, lo, hi, v;
    prev = 0;
    exp_h.delete(); exp_v.delete();
    for (int c = 0; c < W; c++) begin
      v  = row_of(samp[c]);
      lo = (c == 0) ? v : ((v < prev) ? v : prev);
      hi = (c == 0) ? v : ((v > prev) ? v : prev);
      for (int y = lo; y <= hi; y++) begin
        exp_h.push_back(c);
        exp_v.push_back(y);
      end
      prev = v;
    end
  endtask

  function automatic int seq_mismatch(output int first);
    int n = 0;
    int m = (got_h.size() < exp_h.size()) ? got_h.size() : exp_h.size();
    first = -1;
    for (int i = 0; i < m; i++)
      if (got_h[i] != exp_h[i] || got_v[i] != exp_v[i]) begin
        if (first < 0) first = i;
        n++;
      end
    n += (got_h.size() > exp_h.size()) ? got_h.size() - exp_h.size() : exp_h.size() - got_h.size();
    return n;
  endfunction

  task automatic fill_const(input int val);
    samp.delete();
    for (int c = 0; c < W; c++) samp.push_back(val);
  endtask

  task automatic fill_walk();
    int s;
    samp.delete();
    s = int'($urandom_range(0, 255));
    for (int c = 0; c < W; c++) begin
      samp.push_back(s);
      s = s + int'($urandom_range(0, 10)) - 5;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs[7];
    string nm[7];
    rst = 1'b1;
    tick(2);
    obs = '{10'(busy), 10'(frame_done), 10'(sample_ready), 10'(clear), 10'(wren), write_h, write_v};
    nm  = '{"busy", "frame_done", "sample_ready", "clear", "wren", "write_h", "write_v"};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs[i] !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_%s: got %0d want 0", nm[i], obs[i]);
      end
    end
    rst = 1'b0;
    mon_clear();
    tick(5);
    n_checks++;
    if (n_clear !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: clears %0d busy %0b, want 0 and 0", n_clear, busy);
    end
  endtask

  task automatic test_clear();
    bit to;
    early_mode = 1'b1;
    clear_delay = 8;
    fill_const(8'h80);
    src_q = samp;
    mon_clear();
    run_frame(1'b0, to);
    early_mode = 1'b0;
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL clear_timeout: frame_done not seen (got %0b want 0)", to); end
    n_checks++;
    if (n_clear !== 1) begin n_fail++; $display("FAIL clear_cycles: got %0d want 1", n_clear); end
    n_checks++;
    if (n_pre_act !== 0) begin n_fail++; $display("FAIL clear_wait: %0d ready/wren cycles before clear_done, want 0", n_pre_act); end
  endtask

  task automatic test_constant();
    bit to;
    int first, bad;
    clear_delay = 3;
    fill_const(8'h80);
    build_expected();
    src_q = samp;
    mon_clear();
    run_frame(1'b0, to);
    bad = seq_mismatch(first);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL const_timeout: got %0b want 0", to); end
    n_checks++;
    if (got_h.size() !== 640) begin n_fail++; $display("FAIL const_writes: got %0d want 640", got_h.size()); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL const_pixels: %0d bad writes (first idx %0d), want 0", bad, first); end
    n_checks++;
    if (n_done !== 1) begin n_fail++; $display("FAIL const_done: got %0d pulses want 1", n_done); end
    n_checks++;
    if (n_lat_err + n_gap_err !== 0) begin n_fail++; $display("FAIL const_timing: latency %0d gap %0d errors, want 0", n_lat_err, n_gap_err); end
    n_checks++;
    if (n_busy_err + n_overlap + n_bad_data !== 0) begin
      n_fail++;
      $display("FAIL const_flags: busy %0d overlap %0d data %0d errors, want 0", n_busy_err, n_overlap, n_bad_data);
    end
  endtask

  task automatic test_step();
    bit to;
    int first, bad;
    samp.delete();
    samp.push_back(8'h00);
    for (int c = 1; c < W; c++) samp.push_back(8'hFF);
    build_expected();
    src_q = samp;
    mon_clear();
    run_frame(1'b0, to);
    bad = seq_mismatch(first);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL step_timeout: got %0b want 0", to); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL step_pixels: %0d bad writes (first idx %0d), want 0", bad, first); end
    n_checks++;
    if (got_v.size() < 481) begin
      n_fail++;
      $display("FAIL step_len: got %0d writes want at least 481", got_v.size());
    end else if (got_v[0] !== 479 || got_v[1] !== 1 || got_v[479] !== 479 || got_h[479] !== 1 || got_h[480] !== 2) begin
      n_fail++;
      $display("FAIL step_run: col0 v %0d, col1 first %0d last %0d (h %0d), next h %0d; want 479,1,479,1,2",
               got_v[0], got_v[1], got_v[479], got_h[479], got_h[480]);
    end
  endtask

  task automatic test_random_valid();
    bit to;
    int first, bad;
    src_rand = 1'b1;
    fill_const(8'h80);
    build_expected();
    src_q = samp;
    mon_clear();
    run_frame(1'b1, to);
    src_rand = 1'b0;
    bad = seq_mismatch(first);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL rv_timeout: got %0b want 0", to); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rv_pixels: %0d bad writes (first idx %0d), want 0", bad, first); end
    n_checks++;
    if (n_clear !== 1 || n_done !== 1) begin n_fail++; $display("FAIL rv_restart: clears %0d dones %0d, want 1 and 1", n_clear, n_done); end
    n_checks++;
    if (n_lat_err + n_gap_err !== 0) begin n_fail++; $display("FAIL rv_timing: latency %0d gap %0d errors, want 0", n_lat_err, n_gap_err); end
  endtask

  task automatic test_reset_mid_frame();
    bit to, found;
    int first, bad;
    samp.delete();
    for (int c = 0; c < 100; c++) samp.push_back(8'h00);
    for (int c = 100; c < W; c++) samp.push_back(8'hFF);
    src_q = samp;
    mon_clear();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      tick(1);
      found = (wren === 1'b1 && write_h === 10'd100);
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach: col 100 draw seen %0b want 1", found); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (wren !== 1'b0 || busy !== 1'b0 || clear !== 1'b0 || sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: wren %0b busy %0b clear %0b ready %0b, want all 0", wren, busy, clear, sample_ready);
    end
    tick(1);
    rst = 1'b0;
    src_q.delete();
    tick(2);
    fill_walk();
    build_expected();
    src_q = samp;
    mon_clear();
    run_frame(1'b0, to);
    bad = seq_mismatch(first);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL mid_timeout: got %0b want 0", to); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL mid_pixels: %0d bad writes (first idx %0d), want 0", bad, first); end
    n_checks++;
    if (n_clear !== 1) begin n_fail++; $display("FAIL mid_clear: got %0d clears want 1", n_clear); end
  endtask

  task automatic test_boundary();
    bit to;
    int first, bad;
    fill_walk();
    build_expected();
    src_q = samp;
    for (int i = 0; i < 3; i++) src_q.push_back(int'($urandom_range(0, 255)));
    mon_clear();
    run_frame(1'b0, to);
    tick(6);
    bad = seq_mismatch(first);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL bnd_timeout: got %0b want 0", to); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bnd_pixels: %0d bad writes (first idx %0d), want 0", bad, first); end
    n_checks++;
    if (got_h.size() == 0 || got_h[got_h.size()-1] !== 639) begin
      n_fail++;
      $display("FAIL bnd_last_col: got %0d writes, last col %0d want 639", got_h.size(),
               (got_h.size() == 0) ? -1 : got_h[got_h.size()-1]);
    end
    n_checks++;
    if (n_done !== 1 || busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_done: pulses %0d busy_at_done %0b, want 1 and 0", n_done, busy_at_done);
    end
    n_checks++;
    if (src_q.size() !== 3 || n_idle_act !== 0 || sample_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_idle: leftover %0d idle_act %0d ready %0b busy %0b, want 3,0,0,0",
               src_q.size(), n_idle_act, sample_ready, busy);
    end
    src_q.delete();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_constant();
    test_step();
    test_random_valid();
    test_reset_mid_frame();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
